// File: rtl/fp_pkg.sv
// Shared definitions for the (S,E,F) floating-point sample compressor/expander pair.
package fp_pkg;

  localparam int FP_EXP_W  = 3;
  localparam int FP_FRAC_W = 4;
  localparam int FP_DATA_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FIN,
    ST_OUT
  } fp_state_t;

  typedef struct packed {
    logic                 s;
    logic [FP_EXP_W-1:0]  e;
    logic [FP_FRAC_W-1:0] f;
  } fp_code_t;

endpackage

// File: rtl/fp_sign_apply.sv
// Final reconstruction step: optional midpoint rounding, zero forcing, then sign application.
module fp_sign_apply
  import fp_pkg::*;
#(
  parameter int W = FP_DATA_W
) (
  input  logic [W-1:0]        mag,
  input  logic [FP_EXP_W-1:0] e,
  input  logic                f_zero,
  input  logic                s,
  input  logic                round_mid,
  output logic [W-1:0]        result
);

  logic [W-1:0] half;
  logic [W-1:0] m;

  always_comb begin
    half = '0;
    if (round_mid && (e != '0)) begin
      half = W'(1) << (e - FP_EXP_W'(1));
    end
    // A zero significand decodes to zero for any E or sign, so -0 never escapes.
    m      = f_zero ? '0 : (mag + half);
    result = s ? (~m + W'(1)) : m;
  end

endmodule

// File: rtl/fp_expander.sv
// Iterative (S,E,F) -> 12-bit two's-complement expander; shifts the significand one bit per clock.
module fp_expander
  import fp_pkg::*;
#(
  parameter bit ROUND_MID = 1'b0,
  parameter int DATA_W    = FP_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_s,
  input  logic [FP_EXP_W-1:0]  in_e,
  input  logic [FP_FRAC_W-1:0] in_f,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 busy
);

  fp_state_t            state_q;
  fp_code_t             code_q;
  fp_code_t             in_code;
  logic [FP_EXP_W-1:0]  cnt_q;
  logic [DATA_W-1:0]    mag_q;
  logic                 out_valid_q;
  logic [DATA_W-1:0]    out_data_q;
  logic [DATA_W-1:0]    result_d;

  assign in_code = '{s: in_s, e: in_e, f: in_f};

  fp_sign_apply #(
    .W(DATA_W)
  ) u_sign_apply (
    .mag      (mag_q),
    .e        (code_q.e),
    .f_zero   (code_q.f == '0),
    .s        (code_q.s),
    .round_mid(ROUND_MID),
    .result   (result_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      cnt_q       <= '0;
      mag_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            code_q  <= in_code;
            cnt_q   <= in_e;
            mag_q   <= DATA_W'(in_f);
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // The cnt==0 pass costs one extra cycle, so SHIFT spans E+1 clocks.
          if (cnt_q != '0) begin
            mag_q <= mag_q << 1;
            cnt_q <= cnt_q - FP_EXP_W'(1);
          end else begin
            state_q <= ST_FIN;
          end
        end
        ST_FIN: begin
          out_data_q  <= result_d;
          out_valid_q <= 1'b1;
          state_q     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Handshake flags are forced low for as long as reset is held.
  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign busy      = rst_n && (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fp_expander.sv
// Bench for fp_expander: both ROUND_MID builds side by side, a cycle model plus directed literal checks.
module tb_fp_expander;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_s;
  logic [2:0] in_e;
  logic [3:0] in_f;
  logic       out_ready;

  logic        ir0, ir1, ov0, ov1, bz0, bz1;
  logic [11:0] od0, od1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fp_expander #(.ROUND_MID(1'b0), .DATA_W(12)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
    .in_s(in_s), .in_e(in_e), .in_f(in_f), .out_valid(ov0),
    .out_ready(out_ready), .out_data(od0), .busy(bz0)
  );

  fp_expander #(.ROUND_MID(1'b1), .DATA_W(12)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .in_s(in_s), .in_e(in_e), .in_f(in_f), .out_valid(ov1),
    .out_ready(out_ready), .out_data(od1), .busy(bz1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Value the code must decode to: F * 2^E (plus half an LSB when rounding), negated if S.
  function automatic logic [11:0] expect_val(input bit s, input int e, input int f, input bit rm);
    int m;
    logic [31:0] mm;
    if (f == 0) return 12'h000;
    m = f * (1 << e);
    if (rm && e > 0) m = m + (1 << (e - 1));
    if (s) m = -m;
    mm = m;
    return mm[11:0];
  endfunction

  // Cycle model: a code accepted in idle appears E+2 edges later and is held until out_ready.
  bit          m_busy = 1'b0;
  bit          m_valid = 1'b0;
  int          m_wait = 0;
  logic [11:0] m_pend [2];
  logic [11:0] m_data [2];

  initial begin
    m_pend[0] = '0; m_pend[1] = '0;
    m_data[0] = '0; m_data[1] = '0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_wait  = 0;
      m_data[0] = '0;
      m_data[1] = '0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid = 1'b0;
        m_busy  = 1'b0;
      end
    end else if (m_busy) begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid   = 1'b1;
        m_data[0] = m_pend[0];
        m_data[1] = m_pend[1];
      end
    end else if (in_valid) begin
      m_busy    = 1'b1;
      m_wait    = int'(in_e) + 2;
      m_pend[0] = expect_val(in_s, int'(in_e), int'(in_f), 1'b0);
      m_pend[1] = expect_val(in_s, int'(in_e), int'(in_f), 1'b1);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_in_ready0", 32'(ir0), 32'(rst_n && !m_busy));
      chk("cyc_in_ready1", 32'(ir1), 32'(rst_n && !m_busy));
      chk("cyc_busy0", 32'(bz0), 32'(rst_n && m_busy));
      chk("cyc_busy1", 32'(bz1), 32'(rst_n && m_busy));
      chk("cyc_out_valid0", 32'(ov0), 32'(m_valid));
      chk("cyc_out_valid1", 32'(ov1), 32'(m_valid));
      chk("cyc_out_data0", 32'(od0), 32'(m_data[0]));
      chk("cyc_out_data1", 32'(od1), 32'(m_data[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_code(input bit s, input int e, input int f, output int lat);
    in_valid = 1'b1;
    in_s = s;
    in_e = 3'(e);
    in_f = 4'(f);
    tick();
    in_valid = 1'b0;
    in_s = 1'($urandom);
    in_e = 3'($urandom);
    in_f = 4'($urandom);
    lat = 0;
    while (ov0 !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    $display("code s=%0d e=%0d f=%0d lat=%0d data0=%h data1=%h", s, e, f, lat, od0, od1);
  endtask

  typedef struct {
    bit s;
    int e;
    int f;
  } vec_t;

  vec_t vecs [5] = '{'{0, 2, 3}, '{1, 0, 1}, '{1, 4, 8}, '{0, 7, 15}, '{1, 1, 15}};

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; in_s = 1'b0; in_e = '0; in_f = '0; out_ready = 1'b1;

    chk("pin_model_min", 32'(expect_val(0, 0, 11, 0)), 32'h00B);
    chk("pin_model_neg_max", 32'(expect_val(1, 7, 15, 0)), 32'h880);
    chk("pin_model_neg_max_rm", 32'(expect_val(1, 7, 15, 1)), 32'h840);
    chk("pin_model_neg_zero", 32'(expect_val(1, 5, 0, 1)), 32'h000);

    // Reset held two cycles.
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_out_valid", 32'(ov0), 32'h0);
    chk("rst_out_data", 32'(od0), 32'h000);
    chk("rst_in_ready", 32'(ir0), 32'h0);
    chk("rst_busy", 32'(bz1), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(ir0), 32'h1);

    // Minimum latency.
    run_code(0, 0, 11, lat);
    chk("min_lat", 32'(lat), 32'd2);
    chk("min_data0", 32'(od0), 32'h00B);
    chk("min_data1", 32'(od1), 32'h00B);
    tick();
    chk("min_one_wide", 32'(ov0), 32'h0);
    chk("min_in_ready", 32'(ir0), 32'h1);

    // Extreme code.
    run_code(1, 7, 15, lat);
    chk("ext_lat", 32'(lat), 32'd9);
    chk("ext_data0", 32'(od0), 32'h880);
    chk("ext_data1", 32'(od1), 32'h840);
    tick();

    // Backpressure with in_valid pulsing during the stall.
    out_ready = 1'b0;
    run_code(0, 3, 9, lat);
    chk("bp_lat", 32'(lat), 32'd5);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_s = 1'b1; in_e = 3'd1; in_f = 4'd7;
      tick();
      chk("bp_hold_data0", 32'(od0), 32'h048);
      chk("bp_hold_data1", 32'(od1), 32'h04C);
      chk("bp_hold_valid", 32'(ov0), 32'h1);
      chk("bp_in_ready", 32'(ir0), 32'h0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(ov0), 32'h0);
    chk("bp_release_ready", 32'(ir0), 32'h1);
    chk("bp_keep_data", 32'(od0), 32'h048);

    // Negative zero.
    run_code(1, 5, 0, lat);
    chk("nz_lat", 32'(lat), 32'd7);
    chk("nz_data0", 32'(od0), 32'h000);
    chk("nz_data1", 32'(od1), 32'h000);
    tick();

    // Reset during the third SHIFT cycle.
    in_valid = 1'b1; in_s = 1'b0; in_e = 3'd6; in_f = 4'd5;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("abort_busy", 32'(bz0), 32'h0);
    chk("abort_valid", 32'(ov0), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("abort_idle_ready", 32'(ir0), 32'h1);
    run_code(0, 1, 1, lat);
    chk("after_abort_lat", 32'(lat), 32'd3);
    chk("after_abort_data0", 32'(od0), 32'h002);
    chk("after_abort_data1", 32'(od1), 32'h003);
    tick();

    // A spread of further codes against the model.
    foreach (vecs[i]) begin
      run_code(vecs[i].s, vecs[i].e, vecs[i].f, lat);
      chk("vec_lat", 32'(lat), 32'(vecs[i].e + 2));
      chk("vec_data0", 32'(od0), 32'(expect_val(vecs[i].s, vecs[i].e, vecs[i].f, 0)));
      chk("vec_data1", 32'(od1), 32'(expect_val(vecs[i].s, vecs[i].e, vecs[i].f, 1)));
      tick();
    end

    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
